// File: rtl/fwd_hold_unit.sv
// ---------------------------------------------------------------------------
// fwd_hold_unit
//   Operand forwarding and load-use hazard control for the RV32I execute
//   stage. It sits between the ID/EX register outputs and the ALU inputs.
//
//   Forwarding: each of the NUM_SRC execute operands is taken from M
//   (highest priority), then W, then the register file value. Register x0
//   is never forwarded. When an external stall freezes EX, the operand that
//   was live on the first stall cycle is captured. Later stall cycles use
//   the captured copy, so results retiring from M/W during the freeze are
//   not lost.
//
//   Hazards: a load in EX whose rd feeds a decode source freezes F/D and
//   bubbles EX. A saturating counter tracks the bubble cycles.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   rs_D           decode source addresses, slice i = [i*RA_W +: RA_W]
//   rs_E           execute source addresses, same slicing
//   rdata_E        register-file operands in EX, slice i = [i*XLEN +: XLEN]
//   rd_E           EX destination register
//   memRead_E      EX instruction is a load
//   rd_M           M destination register
//   regWrite_M     M writes the register file
//   aluResult_M    M forward value
//   rd_W           W destination register
//   regWrite_W     W writes the register file
//   wd_W           W writeback value
//   stall_ext      external EX freeze
//   flush_E        branch flush of EX
//   fwdData_E      resolved operands
//   fwdSel_E       per-source select: 00 reg, 01 W, 10 M, 11 held
//   stall_F        freeze PC
//   stall_D        freeze IF/ID
//   bubble_E       insert NOP into ID/EX
//   luStallCnt     saturating count of load-use bubble cycles
// ---------------------------------------------------------------------------
module fwd_hold_unit #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int RA_W    = 5,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*RA_W-1:0]   rs_D,
    input  logic [NUM_SRC*RA_W-1:0]   rs_E,
    input  logic [NUM_SRC*XLEN-1:0]   rdata_E,
    input  logic [RA_W-1:0]           rd_E,
    input  logic                      memRead_E,
    input  logic [RA_W-1:0]           rd_M,
    input  logic                      regWrite_M,
    input  logic [XLEN-1:0]           aluResult_M,
    input  logic [RA_W-1:0]           rd_W,
    input  logic                      regWrite_W,
    input  logic [XLEN-1:0]           wd_W,
    input  logic                      stall_ext,
    input  logic                      flush_E,
    output logic [NUM_SRC*XLEN-1:0]   fwdData_E,
    output logic [NUM_SRC*2-1:0]      fwdSel_E,
    output logic                      stall_F,
    output logic                      stall_D,
    output logic                      bubble_E,
    output logic [CNT_W-1:0]          luStallCnt
);

    localparam logic [1:0] SEL_REG  = 2'b00;
    localparam logic [1:0] SEL_W    = 2'b01;
    localparam logic [1:0] SEL_M    = 2'b10;
    localparam logic [1:0] SEL_HELD = 2'b11;

    logic [NUM_SRC-1:0]            held_vld_q, held_vld_d;
    logic [NUM_SRC-1:0][XLEN-1:0]  held_q, held_d;
    logic [NUM_SRC-1:0][XLEN-1:0]  fwd_data;
    logic [NUM_SRC-1:0][1:0]       fwd_sel;
    logic [CNT_W-1:0]              lu_cnt_q, lu_cnt_d;
    logic                          lu;
    logic                          lu_eff;

    // Operand select and mux, zero latency.
    always_comb begin
        fwd_sel  = '0;
        fwd_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (held_vld_q[i]) begin
                fwd_sel[i]  = SEL_HELD;
                fwd_data[i] = held_q[i];
            end else if (regWrite_M && (rd_M != '0) && (rd_M == rs_E[i*RA_W +: RA_W])) begin
                fwd_sel[i]  = SEL_M;
                fwd_data[i] = aluResult_M;
            end else if (regWrite_W && (rd_W != '0) && (rd_W == rs_E[i*RA_W +: RA_W])) begin
                fwd_sel[i]  = SEL_W;
                fwd_data[i] = wd_W;
            end else begin
                fwd_sel[i]  = SEL_REG;
                fwd_data[i] = rdata_E[i*XLEN +: XLEN];
            end
        end
    end

    // Hold capture: the first frozen cycle uses live forwarding and latches
    // it. A flush wins over the stall, so a squashed instruction's operand
    // is never captured.
    always_comb begin
        held_vld_d = held_vld_q;
        held_d     = held_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (flush_E || !stall_ext) begin
                held_vld_d[i] = 1'b0;
            end else if (!held_vld_q[i]) begin
                held_d[i]     = fwd_data[i];
                held_vld_d[i] = 1'b1;
            end
        end
    end

    // Load-use detection uses only addresses and control, never operand data.
    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rs_D[i*RA_W +: RA_W] == rd_E) begin
                lu = 1'b1;
            end
        end
        lu     = lu && memRead_E && (rd_E != '0);
        lu_eff = lu && !flush_E;
    end

    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (bubble_E && (lu_cnt_q != {CNT_W{1'b1}})) begin
            lu_cnt_d = lu_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held_vld_q <= '0;
            held_q     <= '0;
            lu_cnt_q   <= '0;
        end else begin
            held_vld_q <= held_vld_d;
            held_q     <= held_d;
            lu_cnt_q   <= lu_cnt_d;
        end
    end

    assign fwdData_E  = fwd_data;
    assign fwdSel_E   = fwd_sel;
    assign stall_F    = lu_eff || stall_ext;
    assign stall_D    = lu_eff || stall_ext;
    // A frozen EX keeps its instruction, so no bubble goes in.
    assign bubble_E   = lu_eff && !stall_ext;
    assign luStallCnt = lu_cnt_q;

endmodule

// File: tb/tb_fwd_hold_unit.sv
module tb_fwd_hold_unit;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 2;
    localparam int RA_W    = 5;

    logic                    clk;
    logic                    reset;
    logic [NUM_SRC*RA_W-1:0] rs_D;
    logic [NUM_SRC*RA_W-1:0] rs_E;
    logic [NUM_SRC*XLEN-1:0] rdata_E;
    logic [RA_W-1:0]         rd_E;
    logic                    memRead_E;
    logic [RA_W-1:0]         rd_M;
    logic                    regWrite_M;
    logic [XLEN-1:0]         aluResult_M;
    logic [RA_W-1:0]         rd_W;
    logic                    regWrite_W;
    logic [XLEN-1:0]         wd_W;
    logic                    stall_ext;
    logic                    flush_E;

    logic [NUM_SRC*XLEN-1:0] fwdData_E;
    logic [NUM_SRC*2-1:0]    fwdSel_E;
    logic                    stall_F, stall_D, bubble_E;
    logic [15:0]             luStallCnt;

    logic [NUM_SRC*XLEN-1:0] fwdData_E4;
    logic [NUM_SRC*2-1:0]    fwdSel_E4;
    logic                    stall_F4, stall_D4, bubble_E4;
    logic [3:0]              luStallCnt4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fwd_hold_unit #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .RA_W(RA_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .rs_D(rs_D), .rs_E(rs_E), .rdata_E(rdata_E),
        .rd_E(rd_E), .memRead_E(memRead_E), .rd_M(rd_M), .regWrite_M(regWrite_M),
        .aluResult_M(aluResult_M), .rd_W(rd_W), .regWrite_W(regWrite_W), .wd_W(wd_W),
        .stall_ext(stall_ext), .flush_E(flush_E), .fwdData_E(fwdData_E),
        .fwdSel_E(fwdSel_E), .stall_F(stall_F), .stall_D(stall_D),
        .bubble_E(bubble_E), .luStallCnt(luStallCnt)
    );

    fwd_hold_unit #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .RA_W(RA_W), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .rs_D(rs_D), .rs_E(rs_E), .rdata_E(rdata_E),
        .rd_E(rd_E), .memRead_E(memRead_E), .rd_M(rd_M), .regWrite_M(regWrite_M),
        .aluResult_M(aluResult_M), .rd_W(rd_W), .regWrite_W(regWrite_W), .wd_W(wd_W),
        .stall_ext(stall_ext), .flush_E(flush_E), .fwdData_E(fwdData_E4),
        .fwdSel_E(fwdSel_E4), .stall_F(stall_F4), .stall_D(stall_D4),
        .bubble_E(bubble_E4), .luStallCnt(luStallCnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; rs_D = '0; rs_E = '0; rdata_E = '0; rd_E = '0;
        memRead_E = 1'b0; rd_M = '0; regWrite_M = 1'b0; aluResult_M = '0;
        rd_W = '0; regWrite_W = 1'b0; wd_W = '0; stall_ext = 1'b0; flush_E = 1'b0;

        // Reset state
        tick();
        settle();
        check("rst_cnt", 32'(luStallCnt), 32'd0);
        check("rst_sel", 32'(fwdSel_E), 32'd0);
        check("rst_stallF", 32'(stall_F), 32'd0);
        check("rst_bubble", 32'(bubble_E), 32'd0);
        check("rst_data0", fwdData_E[31:0], 32'd0);
        reset = 1'b0;

        // Forward from M beats W
        rs_E = {5'd0, 5'd5}; rdata_E = {32'h0, 32'h33};
        rd_M = 5'd5; regWrite_M = 1'b1; aluResult_M = 32'h11;
        rd_W = 5'd5; regWrite_W = 1'b1; wd_W = 32'h22;
        settle();
        check("m_sel0", 32'(fwdSel_E[1:0]), 32'b10);
        check("m_data0", fwdData_E[31:0], 32'h11);
        check("m_sel1", 32'(fwdSel_E[3:2]), 32'b00);

        // x0 is never forwarded
        rd_M = 5'd0; aluResult_M = 32'hFF; rd_W = 5'd0;
        settle();
        check("x0_sel1", 32'(fwdSel_E[3:2]), 32'b00);
        check("x0_data1", fwdData_E[63:32], 32'h0);
        check("x0_data0", fwdData_E[31:0], 32'h33);

        // Forward from W when M does not write
        rd_M = 5'd5; regWrite_M = 1'b0; rd_W = 5'd5; wd_W = 32'h22;
        settle();
        check("w_sel0", 32'(fwdSel_E[1:0]), 32'b01);
        check("w_data0", fwdData_E[31:0], 32'h22);

        // Load-use hazard
        regWrite_W = 1'b0; rd_W = '0; rd_M = '0;
        memRead_E = 1'b1; rd_E = 5'd7; rs_D = {5'd7, 5'd0};
        settle();
        check("lu_stallF", 32'(stall_F), 32'd1);
        check("lu_stallD", 32'(stall_D), 32'd1);
        check("lu_bubble", 32'(bubble_E), 32'd1);
        check("lu_cnt0", 32'(luStallCnt), 32'd0);
        tick();
        memRead_E = 1'b0; rd_E = 5'd0;
        settle();
        check("lu_cnt1", 32'(luStallCnt), 32'd1);
        check("lu_clr_stallF", 32'(stall_F), 32'd0);
        check("lu_clr_bubble", 32'(bubble_E), 32'd0);
        tick();
        check("lu_cnt_keep", 32'(luStallCnt), 32'd1);

        // Flush masks load-use
        memRead_E = 1'b1; rd_E = 5'd7; flush_E = 1'b1;
        settle();
        check("fl_lu_bubble", 32'(bubble_E), 32'd0);
        check("fl_lu_stallF", 32'(stall_F), 32'd0);
        tick();
        check("fl_lu_cnt", 32'(luStallCnt), 32'd1);
        memRead_E = 1'b0; rd_E = '0; flush_E = 1'b0; rs_D = '0;

        // Stall hold for three cycles
        rs_E = {5'd0, 5'd3}; rdata_E = {32'h0, 32'h55};
        rd_W = 5'd3; regWrite_W = 1'b1; wd_W = 32'hABCD; stall_ext = 1'b1;
        settle();
        check("hold_c1_sel0", 32'(fwdSel_E[1:0]), 32'b01);
        check("hold_c1_data0", fwdData_E[31:0], 32'hABCD);
        check("hold_stallF", 32'(stall_F), 32'd1);
        check("hold_bubble", 32'(bubble_E), 32'd0);
        tick();
        rd_W = 5'd9; wd_W = 32'h1234;
        settle();
        check("hold_c2_sel0", 32'(fwdSel_E[1:0]), 32'b11);
        check("hold_c2_data0", fwdData_E[31:0], 32'hABCD);
        check("hold_c2_sel1", 32'(fwdSel_E[3:2]), 32'b11);
        check("hold_c2_data1", fwdData_E[63:32], 32'h0);
        tick();
        check("hold_c3_sel0", 32'(fwdSel_E[1:0]), 32'b11);
        check("hold_c3_data0", fwdData_E[31:0], 32'hABCD);
        stall_ext = 1'b0;
        tick();
        check("hold_rel_sel0", 32'(fwdSel_E[1:0]), 32'b00);
        check("hold_rel_data0", fwdData_E[31:0], 32'h55);

        // Flush during stall drops held value without recapturing
        rd_W = 5'd3; wd_W = 32'h77; stall_ext = 1'b1;
        tick();
        check("fl_held_sel0", 32'(fwdSel_E[1:0]), 32'b11);
        check("fl_held_data0", fwdData_E[31:0], 32'h77);
        flush_E = 1'b1;
        tick();
        check("fl_sel0", 32'(fwdSel_E[1:0]), 32'b01);
        flush_E = 1'b0;
        tick();
        check("fl_recap_sel0", 32'(fwdSel_E[1:0]), 32'b11);
        reset = 1'b1;
        tick();
        check("rst_mid_sel0", 32'(fwdSel_E[1:0]), 32'b01);
        check("rst_mid_cnt", 32'(luStallCnt), 32'd0);
        reset = 1'b0; stall_ext = 1'b0; regWrite_W = 1'b0;
        tick();

        // Counter saturation (CNT_W=4 instance)
        memRead_E = 1'b1; rd_E = 5'd7; rs_D = {5'd7, 5'd0};
        for (int k = 0; k < 20; k++) tick();
        check("sat_cnt4", 32'(luStallCnt4), 32'd15);
        check("sat_cnt16", 32'(luStallCnt), 32'd20);
        check("sat_bubble4", 32'(bubble_E4), 32'd1);
        memRead_E = 1'b0; rd_E = '0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
